simon_button_conditioner: RTL and testbench

Input-side counterpart to the game FSM's `btn` port. It synchronizes the four raw push-button pins and debounces each one against the shared `ticks_per_milli` millisecond base. A press arbiter then delivers a clean `btn` vector: either all zeros or exactly one bit set, held for as long as that single button is held. It sits between the board pins and the Simon game core and also provides one-cycle press/release strobes plus an encoded button index.

---
 rtl/simon_button_conditioner.sv | 172 +++++++++++++++++
 tb/tb_simon_button_conditioner.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_button_conditioner.sv
// -----------------------------------------------------------------------------
// simon_button_conditioner
//
// Turns the four raw push-button pins of the Simon board into a clean button
// vector for the game core. Each pin is synchronized, debounced against a
// shared millisecond tick, and passed through a press arbiter. The arbiter
// delivers at most one button at a time and ignores simultaneous presses and
// roll-overs.
//
// Ports
//   clk             : system clock
//   rst             : synchronous, active-low reset
//   ticks_per_milli : clock cycles per millisecond minus 1
//   btn_raw         : asynchronous, active-high button pins (bit i = button i)
//   btn             : conditioned buttons, 0000 or one-hot (registered)
//   press           : one-cycle strobe when btn goes 0000 -> one-hot
//   release_stb     : one-cycle strobe when btn returns to 0000
//                     ("release" itself is a reserved word in SystemVerilog)
//   code            : index of the set bit of btn, held while btn = 0000
//   state_dbg       : current arbiter state (IDLE=0, HELD=1, DRAIN=2)
//
// Handshake: there is no valid/ready pairing on this block. press and
// release_stb are single-cycle strobes with no back-pressure. btn and code
// are level outputs that are valid in every cycle.
// -----------------------------------------------------------------------------
module simon_button_conditioner #(
    parameter int DEBOUNCE_MS = 20  // legal range 1..255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ticks_per_milli,
    input  logic [3:0]  btn_raw,
    output logic [3:0]  btn,
    output logic        press,
    output logic        release_stb,
    output logic [1:0]  code,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HELD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_MS);

    state_t          state;
    logic [3:0]      sync_meta;
    logic [3:0]      sync;
    logic [15:0]     tick_cnt;
    logic            ms_tick;
    logic [3:0][7:0] cnt;
    logic [3:0]      stable;
    logic            stable_onehot;
    logic [1:0]      stable_idx;

    // ------------------------------------------------------------------
    // Two-flop synchronizer for the asynchronous pins.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_meta <= 4'b0000;
            sync      <= 4'b0000;
        end else begin
            sync_meta <= btn_raw;
            sync      <= sync_meta;
        end
    end

    // ------------------------------------------------------------------
    // Millisecond tick. The compare is an equality, so lowering
    // ticks_per_milli below the current count lets the counter run on
    // and wrap through 16 bits before the next tick.
    // ------------------------------------------------------------------
    assign ms_tick = (tick_cnt == ticks_per_milli);

    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_cnt <= 16'd0;
        end else if (ms_tick) begin
            tick_cnt <= 16'd0;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Per-bit debounce. Any cycle where the synchronized input agrees
    // with the debounced value clears the count, so a glitch shorter
    // than the window never flips stable.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt    <= '0;
            stable <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync[i] == stable[i]) begin
                    cnt[i] <= 8'd0;
                end else if (ms_tick) begin
                    if (cnt[i] + 8'd1 == DB_LIMIT) begin
                        stable[i] <= sync[i];
                        cnt[i]    <= 8'd0;
                    end else begin
                        cnt[i] <= cnt[i] + 8'd1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // One-hot detect and index encode of the debounced vector.
    // ------------------------------------------------------------------
    always_comb begin
        stable_onehot = (stable != 4'b0000) &&
                        ((stable & (stable - 4'd1)) == 4'b0000);
        stable_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (stable[i]) begin
                stable_idx = 2'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Press arbiter. Only a lone button is accepted. Once it is let go,
    // DRAIN waits for every button to be up, so a rolled-over second
    // button cannot register without being pressed again.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            btn         <= 4'b0000;
            press       <= 1'b0;
            release_stb <= 1'b0;
            code        <= 2'd0;
        end else begin
            press       <= 1'b0;
            release_stb <= 1'b0;
            case (state)
                IDLE: begin
                    if (stable_onehot) begin
                        btn   <= stable;
                        code  <= stable_idx;
                        press <= 1'b1;
                        state <= HELD;
                    end
                end
                HELD: begin
                    if (!stable[code]) begin
                        btn         <= 4'b0000;
                        release_stb <= 1'b1;
                        state       <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (stable == 4'b0000) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_simon_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_simon_button_conditioner
//
// Two instances: dut_a (DEBOUNCE_MS=4) is followed cycle by cycle by a
// behavioural model and exercised by directed scenarios plus random button
// traffic. dut_b (DEBOUNCE_MS=1, one tick per cycle) covers the fast-tick
// case with exact cycle checks.
// -----------------------------------------------------------------------------
module tb_simon_button_conditioner;

    localparam int D_A = 4;
    localparam int D_B = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] tpm;
    logic [15:0] tpm_b;
    logic [3:0]  raw_a;
    logic [3:0]  raw_b;

    logic [3:0]  a_btn;
    logic        a_press;
    logic        a_rel;
    logic [1:0]  a_code;
    logic [1:0]  a_state;
    logic [3:0]  b_btn;
    logic        b_press;
    logic        b_rel;
    logic [1:0]  b_code;
    logic [1:0]  b_state;

    simon_button_conditioner #(.DEBOUNCE_MS(D_A)) dut_a (
        .clk             (clk),
        .rst             (rst),
        .ticks_per_milli (tpm),
        .btn_raw         (raw_a),
        .btn             (a_btn),
        .press           (a_press),
        .release_stb     (a_rel),
        .code            (a_code),
        .state_dbg       (a_state)
    );

    simon_button_conditioner #(.DEBOUNCE_MS(D_B)) dut_b (
        .clk             (clk),
        .rst             (rst),
        .ticks_per_milli (tpm_b),
        .btn_raw         (raw_b),
        .btn             (b_btn),
        .press           (b_press),
        .release_stb     (b_rel),
        .code            (b_code),
        .state_dbg       (b_state)
    );

    int tests = 0;
    int fails = 0;

    // ---------------- reference model for dut_a ----------------
    // Debounce is judged arithmetically: ticks fall on edge indices e with
    // e mod (T+1) == T (counting edges since reset), so the number of ticks
    // seen from the first mismatching edge s through edge e is
    // (e+1)/(T+1) - s/(T+1). The debounced value flips once that reaches D.
    int         m_edges;
    logic [3:0] m_s1, m_s2, m_stable;
    int         m_start [4];
    logic [3:0] m_btn;
    logic       m_press, m_rel;
    logic [1:0] m_code;
    int         m_hold;    // index of the accepted button, -1 if none
    bit         m_drain;   // waiting for all buttons up

    task automatic model_edge(input logic r, input logic [15:0] t, input logic [3:0] raw);
        int p;
        int ticks;
        if (!r) begin
            m_edges = 0; m_s1 = 0; m_s2 = 0; m_stable = 0;
            for (int i = 0; i < 4; i++) m_start[i] = -1;
            m_btn = 0; m_press = 0; m_rel = 0; m_code = 0;
            m_hold = -1; m_drain = 0;
            return;
        end
        p = int'(t) + 1;
        m_press = 0;
        m_rel   = 0;
        if (m_hold >= 0) begin
            if (!m_stable[m_hold]) begin
                m_btn = 0; m_rel = 1; m_hold = -1; m_drain = 1;
            end
        end else if (m_drain) begin
            if (m_stable == 0) m_drain = 0;
        end else if ($countones(m_stable) == 1) begin
            for (int i = 0; i < 4; i++) if (m_stable[i]) m_hold = i;
            m_btn = m_stable; m_code = 2'(m_hold); m_press = 1;
        end
        for (int i = 0; i < 4; i++) begin
            if (m_s2[i] == m_stable[i]) begin
                m_start[i] = -1;
            end else begin
                if (m_start[i] < 0) m_start[i] = m_edges;
                ticks = (m_edges + 1) / p - m_start[i] / p;
                if (ticks >= D_A) begin
                    m_stable[i] = m_s2[i];
                    m_start[i]  = -1;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = raw;
        m_edges++;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // One clock: inputs set before the edge are captured for the model,
    // outputs are sampled 1 time unit after the edge.
    task automatic step();
        logic        r;
        logic [15:0] t;
        logic [3:0]  ra;
        r = rst; t = tpm; ra = raw_a;
        @(posedge clk);
        #1;
        model_edge(r, t, ra);
        check("a_vs_model", {a_btn, a_press, a_rel, a_code},
              {m_btn, m_press, m_rel, m_code});
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset(input logic [15:0] t);
        rst = 1'b0;
        tpm = t;
        steps(2);
        rst = 1'b1;
    endtask

    // Steps until a press strobe on dut_a; lat = steps taken, -1 on timeout.
    task automatic wait_press(input int limit, output int lat);
        lat = -1;
        for (int k = 1; k <= limit; k++) begin
            step();
            if (a_press) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic wait_release(input int limit, output int lat);
        lat = -1;
        for (int k = 1; k <= limit; k++) begin
            step();
            if (a_rel) begin
                lat = k;
                break;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int n_press;
        int n_rel;
        int lat_press;
        int lat_rel;
        logic [3:0] btn_at;
        logic [1:0] code_at;

        rst = 1'b0; tpm = 16'd9; tpm_b = 16'd0; raw_a = 4'b0; raw_b = 4'b0;
        steps(2);
        check("reset_a", {a_btn, a_press, a_rel, a_code}, 32'h0);
        check("reset_b", {b_btn, b_press, b_rel, b_code}, 32'h0);
        rst = 1'b1;
        steps(5);

        // Clean press on button 2, T=9.
        raw_a[2] = 1'b1;
        n_press = 0; lat_press = -1; btn_at = 0; code_at = 0;
        for (int k = 1; k <= 200; k++) begin
            step();
            if (a_press) begin
                n_press++;
                if (lat_press < 0) begin
                    lat_press = k; btn_at = a_btn; code_at = a_code;
                end
            end
        end
        check("clean_press_count", n_press, 1);
        check("clean_press_window", (lat_press >= 34 && lat_press <= 43), 1);
        check("clean_btn", btn_at, 4'b0100);
        check("clean_code", code_at, 2'd2);
        raw_a[2] = 1'b0;
        n_rel = 0; lat_rel = -1;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (a_rel) begin
                n_rel++;
                if (lat_rel < 0) lat_rel = k;
            end
        end
        check("clean_release_count", n_rel, 1);
        check("clean_release_window", (lat_rel >= 34 && lat_rel <= 43), 1);
        check("clean_btn_off", a_btn, 4'b0000);

        // Bounce on button 0: 15-cycle toggles never settle.
        n_press = 0;
        for (int seg = 0; seg < 8; seg++) begin
            raw_a[0] = (seg % 2 == 0);
            for (int k = 0; k < 15; k++) begin
                step();
                if (a_press) n_press++;
            end
        end
        check("bounce_no_press", n_press, 0);
        raw_a[0] = 1'b1;
        wait_press(60, lat);
        check("bounce_press_window", (lat >= 34 && lat <= 43), 1);
        check("bounce_btn", a_btn, 4'b0001);
        raw_a[0] = 1'b0;
        steps(60);

        // Simultaneous press of buttons 1 and 3.
        raw_a = 4'b1010;
        n_press = 0; n_rel = 0;
        for (int k = 0; k < 300; k++) begin
            step();
            if (a_press) n_press++;
            if (a_rel) n_rel++;
        end
        check("simul_no_press", n_press, 0);
        check("simul_no_release", n_rel, 0);
        check("simul_btn", a_btn, 4'b0000);
        raw_a[3] = 1'b0;
        wait_press(60, lat);
        check("simul_drop_window", (lat >= 34 && lat <= 43), 1);
        check("simul_drop_btn", a_btn, 4'b0010);
        check("simul_drop_code", a_code, 2'd1);
        raw_a = 4'b0000;
        steps(60);

        // Roll-over from button 0 to button 1.
        raw_a[0] = 1'b1;
        wait_press(60, lat);
        check("roll_first_btn", a_btn, 4'b0001);
        raw_a[1] = 1'b1;
        steps(60);
        raw_a[0] = 1'b0;
        wait_release(60, lat);
        check("roll_release_seen", (lat > 0), 1);
        n_press = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (a_press || a_btn != 4'b0000) n_press++;
        end
        check("roll_second_ignored", n_press, 0);
        raw_a[1] = 1'b0;
        steps(60);
        raw_a[1] = 1'b1;
        wait_press(60, lat);
        check("roll_repress_btn", a_btn, 4'b0010);
        raw_a[1] = 1'b0;
        steps(60);

        // Reset while button 3 is held.
        raw_a[3] = 1'b1;
        wait_press(60, lat);
        check("rst_hold_btn", a_btn, 4'b1000);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("rst_btn_clear", a_btn, 4'b0000);
        check("rst_code_clear", a_code, 2'd0);
        check("rst_no_release", a_rel, 1'b0);
        wait_press(60, lat);
        check("rst_reregister_window", (lat >= 34 && lat <= 43), 1);
        check("rst_reregister_btn", a_btn, 4'b1000);
        raw_a[3] = 1'b0;
        steps(60);

        // Fast tick on dut_b: T=0, DEBOUNCE_MS=1, 2-cycle pulse on button 2.
        raw_b[2] = 1'b1;
        steps(2);
        raw_b[2] = 1'b0;
        step();
        check("fast_btn_cycle3", b_btn, 4'b0000);
        step();
        check("fast_btn_cycle4", b_btn, 4'b0100);
        check("fast_press_cycle4", b_press, 1'b1);
        step();
        check("fast_btn_hold", b_btn, 4'b0100);
        step();
        check("fast_btn_off", b_btn, 4'b0000);
        check("fast_release", b_rel, 1'b1);

        // Random traffic on dut_a for several tick periods.
        for (int r = 0; r < 4; r++) begin
            do_reset(16'($urandom_range(0, 5)));
            raw_a = 4'b0000;
            for (int seg = 0; seg < 30; seg++) begin
                if ($urandom_range(0, 3) == 0)
                    raw_a = 4'($urandom_range(0, 15));
                else
                    raw_a[$urandom_range(0, 3)] = ~raw_a[$urandom_range(0, 3)];
                steps($urandom_range(1, 60));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
